// File: rtl/bt_telem_pkg.sv
// Shared types and constants for the Bluetooth telemetry transmitter:
// frame layout, FSM state encodings and the frame builder.
package bt_telem_pkg;

    localparam logic [7:0] TELEM_HDR = 8'hA5;
    localparam int         TELEM_LEN = 5;

    typedef enum logic [1:0] {
        FR_IDLE,
        FR_LOAD,
        FR_SEND,
        FR_DONE
    } frame_state_e;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_START,
        SER_DATA,
        SER_STOP
    } ser_state_e;

    typedef logic [TELEM_LEN-1:0][7:0] telem_frame_t;

    // An invalid distance is sent as 0xFFFF so the receiver can tell it apart.
    function automatic telem_frame_t build_frame(
        input logic [2:0]  ctr,
        input logic [1:0]  hwsignal,
        input logic [15:0] dist_cm,
        input logic        dist_valid
    );
        telem_frame_t f;
        f[0] = TELEM_HDR;
        f[1] = {3'b000, hwsignal, ctr};
        f[2] = dist_valid ? dist_cm[15:8] : 8'hFF;
        f[3] = dist_valid ? dist_cm[7:0]  : 8'hFF;
        f[4] = f[0] + f[1] + f[2] + f[3];
        return f;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser. Accepts a new byte on the last stop-bit cycle so
// consecutive bytes leave the line with no idle gap.
module uart_tx_byte
    import bt_telem_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int CW = $clog2(DIV);

    ser_state_e     state_q, state_d;
    logic [CW-1:0]  baud_q, baud_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_q, tx_d;
    logic           last;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        last    = (baud_q == CW'(DIV - 1));
        done    = (state_q == SER_STOP) && last;

        unique case (state_q)
            SER_IDLE: begin
                tx_d = 1'b1;
                if (start) begin
                    state_d = SER_START;
                    shift_d = data;
                    baud_d  = '0;
                    tx_d    = 1'b0;
                end
            end
            SER_START: begin
                if (last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = SER_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            SER_DATA: begin
                if (last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = SER_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            SER_STOP: begin
                if (last) begin
                    baud_d = '0;
                    if (start) begin
                        state_d = SER_START;
                        shift_d = data;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = SER_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = SER_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SER_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx = tx_q;

endmodule

// File: rtl/bt_telemetry_tx.sv
// Telemetry framer: snapshots motion/IR/distance into a 5-byte packet and
// sends it as 8N1 UART. Optional auto-send enabled by macro TELEM_PERIODIC_EN.
module bt_telemetry_tx
    import bt_telem_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 9600,
    parameter int PERIOD_MS = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  ctr,
    input  logic [1:0]  hwsignal,
    input  logic [15:0] dist_cm,
    input  logic        dist_valid,
    input  logic        send_req,
    output logic        tx,
    output logic        busy,
    output logic        frame_done
);

    localparam int DIV = CLK_HZ / BAUD;

    if (DIV < 2 || PERIOD_MS < 1) begin : g_bad_cfg
        $error("bt_telemetry_tx: CLK_HZ/BAUD must be >= 2 and PERIOD_MS >= 1");
    end

    logic tick;

`ifdef TELEM_PERIODIC_EN
    localparam longint unsigned PERIOD_CYC =
        64'(PERIOD_MS) * 64'(CLK_HZ) / 64'd1000;
    localparam int PW = $clog2(PERIOD_CYC);

    logic [PW-1:0] per_q, per_d;

    always_comb begin
        per_d = per_q + 1'b1;
        tick  = 1'b0;
        if (per_q == PW'(PERIOD_CYC - 1)) begin
            per_d = '0;
            tick  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) per_q <= '0;
        else        per_q <= per_d;
    end
`else
    assign tick = 1'b0;
`endif

    frame_state_e state_q, state_d;
    telem_frame_t frame_q, frame_d;
    logic [2:0]   idx_q, idx_d;
    logic         pending_q, pending_d;
    logic         trig;
    logic         ser_start, ser_done;
    logic [7:0]   ser_data;

    assign trig = send_req | tick;

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        idx_d     = idx_q;
        pending_d = pending_q | trig;
        ser_start = 1'b0;
        ser_data  = TELEM_HDR;

        unique case (state_q)
            FR_IDLE: begin
                // A trigger coinciding with a pending frame is kept for the next one.
                pending_d = pending_q & trig;
                if (trig || pending_q) state_d = FR_LOAD;
            end
            FR_LOAD: begin
                frame_d   = build_frame(ctr, hwsignal, dist_cm, dist_valid);
                idx_d     = '0;
                ser_start = 1'b1;
                ser_data  = TELEM_HDR;
                state_d   = FR_SEND;
            end
            FR_SEND: begin
                if (ser_done) begin
                    if (idx_q == 3'(TELEM_LEN - 1)) begin
                        state_d = FR_DONE;
                    end else begin
                        idx_d     = idx_q + 1'b1;
                        ser_start = 1'b1;
                        ser_data  = frame_q[idx_q + 3'd1];
                    end
                end
            end
            FR_DONE: state_d = FR_IDLE;
            default: state_d = FR_IDLE;
        endcase
    end

    // NOTE: the frame registers are only a few bytes, so they are reset like any other flop rather than left as uninitialised storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FR_IDLE;
            frame_q   <= '0;
            idx_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
        end
    end

    uart_tx_byte #(
        .DIV (DIV)
    ) u_ser (
        .clk   (clk),
        .rst_n (rst_n),
        .start (ser_start),
        .data  (ser_data),
        .tx    (tx),
        .done  (ser_done)
    );

    assign frame_done = (state_q == FR_DONE);
    assign busy       = (state_q != FR_IDLE) && !((state_q == FR_DONE) && !pending_q);

endmodule

// File: tb/tb_bt_telemetry_tx.sv
// Self-checking bench for bt_telemetry_tx: decodes the UART line with a
// behavioural receiver and compares against frames built from the packet rules.
module tb_bt_telemetry_tx;

    localparam int CLK_HZ = 1000;
    localparam int BAUD   = 100;
    localparam int DIV    = CLK_HZ / BAUD;

    typedef logic [7:0] frame_t [5];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  ctr = '0;
    logic [1:0]  hwsignal = '0;
    logic [15:0] dist_cm = '0;
    logic        dist_valid = 1'b0;
    logic        send_req = 1'b0;
    logic        tx, busy, frame_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic busy_at_done = 1'b0;

    bt_telemetry_tx #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .PERIOD_MS (1000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ctr        (ctr),
        .hwsignal   (hwsignal),
        .dist_cm    (dist_cm),
        .dist_valid (dist_valid),
        .send_req   (send_req),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_done) begin
            done_cnt     = done_cnt + 1;
            done_cyc     = cyc;
            busy_at_done = busy;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Packet rules written out with plain arithmetic.
    function automatic frame_t model_frame(input int c, input int h, input int d, input bit v);
        frame_t f;
        int s;
        f[0] = 8'hA5;
        f[1] = 8'(h * 8 + c);
        f[2] = v ? 8'(d / 256) : 8'hFF;
        f[3] = v ? 8'(d % 256) : 8'hFF;
        s = 0;
        for (int i = 0; i < 4; i++) s += int'(f[i]);
        f[4] = 8'(s % 256);
        return f;
    endfunction

    // Receiver: find the start edge, then sample each bit at its middle.
    task automatic rx_byte(output logic [7:0] b, output int st, output bit ok);
        int n = 0;
        ok = 1'b0;
        b  = '0;
        st = 0;
        while (tx !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (tx !== 1'b0) return;
        st = cyc;
        repeat (DIV / 2) @(negedge clk);
        if (tx !== 1'b0) return;
        for (int k = 0; k < 8; k++) begin
            repeat (DIV) @(negedge clk);
            b[k] = tx;
        end
        repeat (DIV) @(negedge clk);
        if (tx !== 1'b1) return;
        ok = 1'b1;
    endtask

    task automatic watch_idle(input int n, output bit tx_low, output bit busy_seen);
        tx_low = 1'b0;
        busy_seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_low = 1'b1;
            if (busy !== 1'b0) busy_seen = 1'b1;
        end
    endtask

    task automatic pulse_req();
        send_req = 1'b1;
        @(negedge clk);
        send_req = 1'b0;
    endtask

    task automatic send_and_check(input frame_t exp, input string tag, input bit scramble);
        int   req, d0, st0, n;
        int   st [5];
        bit   ok;
        logic [7:0] b;
        @(negedge clk);
        d0  = done_cnt;
        req = cyc;
        pulse_req();
        check({tag, "_busy_n1"}, 32'(busy), 32'd1);
        check({tag, "_tx_n1"}, 32'(tx), 32'd1);
        for (int i = 0; i < 5; i++) begin
            rx_byte(b, st[i], ok);
            check($sformatf("%s_ok%0d", tag, i), 32'(ok), 32'd1);
            check($sformatf("%s_byte%0d", tag, i), 32'(b), 32'(exp[i]));
            if (i == 0 && scramble) begin
                ctr = 3'($urandom);
                hwsignal = 2'($urandom);
                dist_cm = 16'($urandom);
                dist_valid = 1'($urandom);
            end
        end
        st0 = st[0];
        check({tag, "_start_lat"}, 32'(st0), 32'(req + 2));
        for (int i = 1; i < 5; i++)
            check($sformatf("%s_start%0d", tag, i), 32'(st[i]), 32'(st0 + 10 * DIV * i));
        n = 0;
        while (done_cnt == d0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'(d0 + 1));
        check({tag, "_done_cyc"}, 32'(done_cyc), 32'(st0 + 50 * DIV));
        check({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
        @(negedge clk);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        frame_t e;
        frame_t e2;
        bit     tx_low, busy_seen, ok;
        int     d0, d1, st0, n;
        int     st [10];
        logic [7:0] rb [10];
        bit     rok [10];
        logic [15:0] old_d, new_d;
        logic [7:0] b;

        // Scenario 1: reset state and quiet line.
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_tx", 32'(tx), 32'd1);
        check("post_rst_done", 32'(frame_done), 32'd0);
        watch_idle(1000, tx_low, busy_seen);
        check("idle_tx_low", 32'(tx_low), 32'd0);
        check("idle_busy", 32'(busy_seen), 32'd0);
        check("idle_done_cnt", 32'(done_cnt), 32'd0);

        // Scenario 2: known frame.
        ctr = 3'b101; hwsignal = 2'b10; dist_cm = 16'h0123; dist_valid = 1'b1;
        e = '{8'hA5, 8'h15, 8'h01, 8'h23, 8'hDE};
        send_and_check(e, "s2", 1'b0);

        // Scenario 3: invalid distance.
        ctr = 3'b101; hwsignal = 2'b10; dist_cm = 16'h0123; dist_valid = 1'b0;
        e = '{8'hA5, 8'h15, 8'hFF, 8'hFF, 8'hB8};
        send_and_check(e, "s3", 1'b0);

        // Scenario 4: three extra requests mid-frame -> exactly one more frame.
        ctr = 3'($urandom); hwsignal = 2'($urandom); dist_valid = 1'b1;
        old_d = 16'($urandom);
        new_d = old_d ^ 16'h5A3C;
        dist_cm = old_d;
        e  = model_frame(int'(ctr), int'(hwsignal), int'(old_d), 1'b1);
        e2 = model_frame(int'(ctr), int'(hwsignal), int'(new_d), 1'b1);
        d1 = 0;
        @(negedge clk);
        d0 = done_cnt;
        pulse_req();
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    rx_byte(rb[i], st[i], rok[i]);
                    if (i == 5) d1 = done_cyc;
                end
            end
            begin
                repeat (100) @(negedge clk);
                pulse_req();
                dist_cm = new_d;
                repeat (60) @(negedge clk);
                pulse_req();
                repeat (60) @(negedge clk);
                pulse_req();
            end
        join
        for (int i = 0; i < 5; i++) begin
            check($sformatf("s4_f1_byte%0d", i), 32'(rb[i]), 32'(e[i]));
            check($sformatf("s4_f2_byte%0d", i), 32'(rb[i+5]), 32'(e2[i]));
            check($sformatf("s4_f2_start%0d", i), 32'(st[i+5]), 32'(st[5] + 10 * DIV * i));
        end
        check("s4_ok", 32'(rok.and()), 32'd1);
        check("s4_f1_done", 32'(d1), 32'(st[0] + 50 * DIV));
        check("s4_pending_gap", 32'(st[5] > d1 && st[5] - d1 <= 4), 32'd1);
        watch_idle(700, tx_low, busy_seen);
        check("s4_frames", 32'(done_cnt - d0), 32'd2);
        check("s4_no_third", 32'(tx_low), 32'd0);

        // Scenario 5: reset during byte 2 with a frame pending.
        dist_valid = 1'b1; dist_cm = 16'($urandom);
        @(negedge clk);
        pulse_req();
        rx_byte(b, st0, ok);
        check("s5_b0_ok", 32'(ok), 32'd1);
        pulse_req();
        n = 0;
        while (cyc < st0 + 203 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("s5_pre_tx", 32'(tx), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("s5_rst_tx", 32'(tx), 32'd1);
        check("s5_rst_busy", 32'(busy), 32'd0);
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        watch_idle(700, tx_low, busy_seen);
        check("s5_post_tx_low", 32'(tx_low), 32'd0);
        check("s5_post_busy", 32'(busy_seen), 32'd0);
        check("s5_post_done", 32'(done_cnt), 32'(d0));

        // Random frames, inputs scrambled while the frame is on the line.
        for (int r = 0; r < 6; r++) begin
            ctr = 3'($urandom);
            hwsignal = 2'($urandom);
            dist_cm = 16'($urandom);
            dist_valid = ($urandom_range(0, 3) != 0);
            e = model_frame(int'(ctr), int'(hwsignal), int'(dist_cm), dist_valid);
            send_and_check(e, $sformatf("rnd%0d", r), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bt_telemetry_tx.md
# bt_telemetry_tx

Telemetry transmitter for the smart car's Bluetooth link: the outbound counterpart to the command receiver. It snapshots the car's motion command, infrared sensor state and ultrasonic distance, and frames them into a fixed 5-byte packet. The packet is serialised as 8N1 UART on `tx`, which feeds the Bluetooth module's RX pin. It sits beside the Bluetooth receiver at top level and shares the same system clock.

## Interface

Parameters:
- `CLK_HZ`, 50_000_000, system clock frequency.
- `BAUD`, 9600, UART bit rate; `DIV = CLK_HZ/BAUD` (integer division, must be ≥ 2).
- `PERIOD_MS`, 100, auto-send interval (used only with `TELEM_PERIODIC_EN`).

Ports:
- `clk`  in  1  system clock; one clock domain only.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ctr`  in  3  active motion command, as driven to the PWM block.
- `hwsignal`  in  2  infrared sensor inputs (already synchronous).
- `dist_cm`  in  16  ultrasonic distance in cm.
- `dist_valid`  in  1  `dist_cm` holds a valid measurement.
- `send_req`  in  1  single-cycle pulse that requests one frame.
- `tx`  out  1  UART serial output; idles high.
- `busy`  out  1  high while a frame is in flight.
- `frame_done`  out  1  one-cycle pulse after the stop bit of byte 4.

## Operation

- Frame format, bytes sent in order 0..4, each byte LSB first:
  - byte 0: `0xA5` (header).
  - byte 1: `{3'b000, hwsignal, ctr}`.
  - byte 2: distance high byte.
  - byte 3: distance low byte.
  - byte 4: checksum = (byte0 + byte1 + byte2 + byte3) mod 256.
- If `dist_valid` is 0 at snapshot time, bytes 2 and 3 are both `0xFF`.
- All inputs are snapshotted into frame registers on the cycle a frame starts. Input changes during the frame have no effect on it.
- Frame FSM states:
  - IDLE: leave when a trigger is present or `pending` is set → LOAD.
  - LOAD: snapshot inputs; byte index = 0 → SEND.
  - SEND: hand the byte to the serialiser and wait for it to finish. Advance the index; after index 4 → DONE.
  - DONE: pulse `frame_done` → IDLE.
- Serialiser FSM states: IDLE → START (tx=0) → DATA (8 bits) → STOP (tx=1) → IDLE. Each state lasts `DIV` cycles per bit.
- Triggers are `send_req`, plus the periodic tick when that feature is compiled in.
- A trigger arriving while `busy` sets a single `pending` flag. Further triggers while `pending` is already set are dropped. `pending` is served immediately after DONE.
- A trigger arriving in the same cycle as DONE sets `pending`; no trigger is lost.

## Timing

- Reset values: `tx`=1, `busy`=0, `frame_done`=0, `pending`=0, both FSMs in IDLE, baud and period counters at 0.
- Asserting `rst_n` low mid-frame forces `tx` high immediately (asynchronously) and aborts the frame. No partial frame resumes after reset is released.
- `send_req` high in cycle N (while idle):
  - `busy`=1 from N+1.
  - Start bit begins in cycle N+2.
- Each bit lasts exactly `DIV` cycles.
- Back-to-back bytes have no idle gap: the stop bit of one byte is followed directly by the start bit of the next.
- One frame occupies 50·`DIV` cycles of line time.
- `frame_done` pulses on the cycle after the last stop-bit cycle. `busy` drops on that same cycle, unless a pending frame starts.

## Configuration

Macro `TELEM_PERIODIC_EN`:
- Defined: a free-running counter emits one trigger every `PERIOD_MS`·`CLK_HZ`/1000 cycles. The counter runs regardless of `busy`; ticks that occur while busy go through the `pending` logic.
- Undefined: there is no period counter, `PERIOD_MS` is ignored, and frames are sent only on `send_req`.

## Structure

- Shared package `bt_telem_pkg`:
  - `TELEM_HDR` = 8'hA5.
  - `TELEM_LEN` = 5.
  - The frame FSM state typedef.
  - The serialiser state typedef.
- One sub-module, `uart_tx_byte`, is natural:
  - Ports: `clk`, `rst_n`, `start`, `data[7:0]`, `tx`, `done`.
  - Parameter: `DIV`.
  - It owns the baud counter and bit counter.

## Test plan

All scenarios use `CLK_HZ`=1000 and `BAUD`=100, so `DIV`=10.

1. Reset with no stimulus → `tx`=1, `busy`=0, and no `frame_done` for 1000 cycles (macro undefined).
2. `ctr`=3'b101, `hwsignal`=2'b10, `dist_cm`=16'h0123, `dist_valid`=1, one `send_req` pulse → line decodes as A5 15 01 23 DE. `frame_done` pulses exactly 500 cycles after the start bit begins.
3. Same as 2 but `dist_valid`=0 → line decodes as A5 15 FF FF B8.
4. Three `send_req` pulses during frame 1, with `dist_cm` changed mid-frame → exactly 2 frames are sent back-to-back. Frame 1 carries the old distance; frame 2 carries the new one.
5. `rst_n` low during byte 2 → `tx`=1 in the same cycle and `busy`=0. After release, `tx` stays high until the next trigger.
6. `TELEM_PERIODIC_EN` defined with `PERIOD_MS`=1000 → a frame starts every 1000 cycles, and the bit timing of each frame matches scenario 2.
